// File: rtl/store_narrow.sv
// store_narrow: writes byte/half/word stores into a 32-bit memory that has
// no byte enables. Sub-word stores read the word, merge the addressed lane
// and write it back. The FSM runs IDLE -> (READ -> MERGE ->) WRITE -> FIN.
// Optional feature macro: STORE_NARROW_OVF_CHECK_EN. When it is defined, ovf
// reports narrow stores whose data does not survive a sign-extension round
// trip. When it is undefined, ovf is tied to 0 and no check logic exists.
`timescale 1ns/1ps

module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t state, state_next;

    // Request fields kept for the read-modify-write. Only the lane select,
    // the size and the low 16 data bits are needed once the request is
    // accepted. Word data goes straight to mem_wdata on accept.
    logic [1:0]  lane_hold;
    logic        half_hold;
    logic [15:0] data_hold;

    logic accept;
    logic req_err;
    logic req_word;

    logic              mem_re_next;
    logic              mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [31:0]       mem_wdata_next;
    logic              done_next;
    logic              err_next;
    logic              ovf_next;

    // Replace the addressed lane(s) of the memory word with the narrow value.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [15:0] val,
                                               input logic [1:0]  lane,
                                               input logic        is_half);
        logic [31:0] r;
        r = word;
        if (is_half) begin
            if (lane[1]) r[31:16] = val;
            else         r[15:0]  = val;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = val[7:0];
                2'd1:    r[15:8]  = val[7:0];
                2'd2:    r[23:16] = val[7:0];
                default: r[31:24] = val[7:0];
            endcase
        end
        return r;
    endfunction

`ifdef STORE_NARROW_OVF_CHECK_EN
    logic ovf_hold;

    // True when sign-extending the narrow value would not give back the data.
    function automatic logic narrow_ovf(input logic [31:0] data,
                                        input logic [1:0]  size);
        logic signed [31:0] sx;
        logic               r;
        r = 1'b0;
        case (size)
            2'b00: begin
                sx = 32'(signed'(data[7:0]));
                r  = (sx != signed'(data));
            end
            2'b01: begin
                sx = 32'(signed'(data[15:0]));
                r  = (sx != signed'(data));
            end
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_word  = (req_size == 2'b10);
    assign req_err   = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)       state_next = S_FIN;
                    else if (req_word) state_next = S_WRITE;
                    else               state_next = S_READ;
                end
            end
            S_READ:  state_next = S_MERGE;
            S_MERGE: state_next = S_WRITE;
            S_WRITE: state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: values the registered outputs take at the next edge.
    always_comb begin
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        done_next      = 1'b0;
        err_next       = 1'b0;
        ovf_next       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end else begin
                        mem_addr_next = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_word) begin
                            mem_we_next    = 1'b1;
                            mem_wdata_next = req_data;
                        end else begin
                            mem_re_next = 1'b1;
                        end
                    end
                end
            end
            S_MERGE: begin
                mem_wdata_next = merge_lane(mem_rdata, data_hold, lane_hold, half_hold);
                mem_we_next    = 1'b1;
            end
            S_WRITE: begin
                done_next = 1'b1;
`ifdef STORE_NARROW_OVF_CHECK_EN
                ovf_next  = ovf_hold;
`endif
            end
            default: ;
        endcase
    end

    // Registered outputs; reset drops the strobes asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            mem_re    <= mem_re_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            done      <= done_next;
            err       <= err_next;
            ovf       <= ovf_next;
        end
    end

    // Latch the request fields on accept; they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_hold <= req_addr[1:0];
            half_hold <= (req_size == 2'b01);
            data_hold <= req_data[15:0];
`ifdef STORE_NARROW_OVF_CHECK_EN
            ovf_hold  <= narrow_ovf(req_data, req_size);
`endif
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Directed testbench for store_narrow with a small word-addressed memory model.
`timescale 1ns/1ps

module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        done, err, ovf;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: 16 words, read data registered one cycle after mem_re.
    logic [31:0] mem [0:15];
    logic        pk_en = 1'b0;
    logic [3:0]  pk_idx = '0;
    logic [31:0] pk_val = '0;

    // Results of the last operation.
    int          re_c, we_c, done_c;
    logic [31:0] w_addr, w_data;
    logic        o_err, o_ovf, rdy_after;

    logic exp_ovf_half;

    store_narrow #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pk_en) mem[pk_idx] <= pk_val;
        if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pk_en = 1'b1; pk_idx = idx; pk_val = val;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // Issue one request and watch up to 10 cycles after the accept edge.
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
        req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        re_c = -1; we_c = -1; done_c = -1;
        w_addr = 'x; w_data = 'x; o_err = 1'bx; o_ovf = 1'bx; rdy_after = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_re && re_c < 0) re_c = c;
            if (mem_we && we_c < 0) begin
                we_c = c; w_addr = mem_addr; w_data = mem_wdata;
            end
            if (done && done_c < 0) begin
                done_c = c; o_err = err; o_ovf = ovf;
            end else if (done_c > 0 && c == done_c + 1) begin
                rdy_after = req_ready;
                break;
            end
        end
    endtask

    initial begin
`ifdef STORE_NARROW_OVF_CHECK_EN
        exp_ovf_half = 1'b1;
`else
        exp_ovf_half = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", {28'd0, mem_re, mem_we, done, err}, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Word store.
        run_op("word", 32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        chk("word_we_cyc", 32'(we_c), 32'd1);
        chk("word_addr", w_addr, 32'h0000_0010);
        chk("word_wdata", w_data, 32'hDEAD_BEEF);
        chk("word_done_cyc", 32'(done_c), 32'd2);
        chk("word_err", 32'(o_err), 32'd0);
        chk("word_ovf", 32'(o_ovf), 32'd0);
        chk("word_no_re", 32'(re_c), 32'hFFFF_FFFF);
        chk("word_ready_after", 32'(rdy_after), 32'd1);
        chk("word_mem", mem[4], 32'hDEAD_BEEF);

        // Byte store into lane 3.
        poke(4'd4, 32'h1122_3344);
        run_op("byte", 32'h0000_0013, 32'h0000_0055, 2'b00);
        chk("byte_re_cyc", 32'(re_c), 32'd1);
        chk("byte_we_cyc", 32'(we_c), 32'd3);
        chk("byte_addr", w_addr, 32'h0000_0010);
        chk("byte_wdata", w_data, 32'h5522_3344);
        chk("byte_done_cyc", 32'(done_c), 32'd4);
        chk("byte_err", 32'(o_err), 32'd0);
        chk("byte_ovf", 32'(o_ovf), 32'd0);
        chk("byte_mem", mem[4], 32'h5522_3344);

        // Half store into the upper half.
        poke(4'd1, 32'h1122_3344);
        run_op("half", 32'h0000_0006, 32'h0000_ABCD, 2'b01);
        chk("half_addr", w_addr, 32'h0000_0004);
        chk("half_wdata", w_data, 32'hABCD_3344);
        chk("half_done_cyc", 32'(done_c), 32'd4);
        chk("half_ovf", 32'(o_ovf), 32'(exp_ovf_half));

        // Misaligned half.
        run_op("mishalf", 32'h0000_0005, 32'h0000_1234, 2'b01);
        chk("mishalf_done_cyc", 32'(done_c), 32'd1);
        chk("mishalf_err", 32'(o_err), 32'd1);
        chk("mishalf_no_re", 32'(re_c), 32'hFFFF_FFFF);
        chk("mishalf_no_we", 32'(we_c), 32'hFFFF_FFFF);
        chk("mishalf_ready_c2", 32'(rdy_after), 32'd1);
        chk("mishalf_ovf", 32'(o_ovf), 32'd0);

        // Illegal size.
        run_op("size11", 32'h0000_0008, 32'h0000_0001, 2'b11);
        chk("size11_done_cyc", 32'(done_c), 32'd1);
        chk("size11_err", 32'(o_err), 32'd1);
        chk("size11_no_access", {re_c[15:0], we_c[15:0]}, 32'hFFFF_FFFF);
        chk("size11_ready_c2", 32'(rdy_after), 32'd1);

        // Misaligned word.
        run_op("misword", 32'h0000_0012, 32'h0000_0001, 2'b10);
        chk("misword_err", 32'(o_err), 32'd1);
        chk("misword_no_we", 32'(we_c), 32'hFFFF_FFFF);

        // Negative byte that sign-extends exactly: lane 1 gets 0x80.
        poke(4'd8, 32'h1122_3344);
        run_op("negbyte", 32'h0000_0021, 32'hFFFF_FF80, 2'b00);
        chk("negbyte_wdata", w_data, 32'h1122_8044);
        chk("negbyte_ovf", 32'(o_ovf), 32'd0);
        chk("negbyte_err", 32'(o_err), 32'd0);

        // Reset in cycle 2 of a byte store.
        poke(4'd2, 32'hCAFE_F00D);
        @(negedge clk);
        req_addr = 32'h0000_0009; req_data = 32'h0000_0077; req_size = 2'b00;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_re_c1", 32'(mem_re), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_we_now", 32'(mem_we), 32'd0);
        chk("rstmid_ready_now", 32'(req_ready), 32'd1);
        begin
            int seen_we, seen_done, seen_notready;
            seen_we = 0; seen_done = 0; seen_notready = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (c == 2) rst = 1'b0;
                if (mem_we) seen_we++;
                if (done) seen_done++;
                if (!req_ready) seen_notready++;
            end
            chk("rstmid_no_we", 32'(seen_we), 32'd0);
            chk("rstmid_no_done", 32'(seen_done), 32'd0);
            chk("rstmid_ready_held", 32'(seen_notready), 32'd0);
        end
        chk("rstmid_mem", mem[2], 32'hCAFE_F00D);

        // Word store after the abandoned one.
        run_op("post", 32'h0000_000C, 32'h0BAD_F00D, 2'b10);
        chk("post_we_cyc", 32'(we_c), 32'd1);
        chk("post_wdata", w_data, 32'h0BAD_F00D);
        chk("post_done_cyc", 32'(done_c), 32'd2);
        chk("post_mem", mem[3], 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
